// File: rtl/kiwi_cpu_glue_if.sv
// Z80 main-CPU bus as seen by the Kiwi glue logic.
// master = CPU side, slave = glue side.
interface kiwi_cpu_glue_if;
  logic        cpu_cen;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic        mreq_n;
  logic        rfsh_n;
  logic        wr_n;
  logic        iorq_n;
  logic [7:0]  cpu_din;
  logic        int_n;
  logic        dev_busy;
  logic        cpu_rnw;

  modport master (
    output cpu_cen, A, cpu_dout, mreq_n, rfsh_n, wr_n, iorq_n,
    input  cpu_din, int_n, dev_busy, cpu_rnw
  );

  modport slave (
    input  cpu_cen, A, cpu_dout, mreq_n, rfsh_n, wr_n, iorq_n,
    output cpu_din, int_n, dev_busy, cpu_rnw
  );
endinterface

// File: rtl/kiwi_cpu_glue.sv
// Kiwi main-CPU glue: address decode, ROM banking, vblank IRQ, read mux
// and a first-come-first-served shared RAM between main and sub CPUs.
module kiwi_cpu_glue #(
  parameter int unsigned AW = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  kiwi_cpu_glue_if.slave       bus,
  input  logic                 LVBL,
  output logic                 rom_cs,
  output logic                 vram_cs,
  output logic                 vctrl_cs,
  output logic                 vflag_cs,
  output logic                 pal_cs,
  output logic [16:0]          rom_addr,
  input  logic [7:0]           rom_data,
  input  logic [7:0]           vram_dout,
  input  logic [7:0]           pal_dout,
  input  logic [8:0]           hcnt,
  input  logic [AW-1:0]        shr_addr,
  input  logic [7:0]           shr_din,
  input  logic                 sub_rnw,
  input  logic                 shr_cs,
  output logic [7:0]           shr_dout,
  output logic                 mshramen,
  output logic                 snd_rstn,
  output logic [7:0]           st_dout
);

  localparam int unsigned DEPTH = 1 << AW;

  logic        mem_acc;
  logic        obj_en;
  logic        ram_cs;
  logic        bank_cs;
  logic        sshramen;
  logic [2:0]  bank;
  logic        lvbl_l;
  logic [7:0]  ram_q;
  logic [7:0]  rd_mux;
  logic        we0;
  logic        we1;
  logic [AW-1:0] addr0;
  logic        unused;

  logic [7:0]  mem [DEPTH];

  assign mem_acc = ~bus.mreq_n & bus.rfsh_n;
  assign addr0   = bus.A[AW-1:0];
  assign unused  = &{1'b0, hcnt[8:2]};

  // Object/video region that must stall while the pixel pipeline fetches
  assign obj_en = mem_acc & (((bus.A[15:11] == 5'b11110) & ~bus.A[9]) |
                             (bus.A[15:10] == 6'b111100) |
                             (bus.A[15:13] == 3'b110));

  assign bus.dev_busy = (sshramen & ram_cs) | (obj_en & (hcnt[1:0] != 2'b00));
  assign bus.cpu_rnw  = bus.wr_n | ~bus.cpu_cen;

  assign rom_addr = bus.A[15] ? {bank, bus.A[13:0]} : {2'b00, bus.A[14], bus.A[13:0]};
  assign st_dout  = {3'b000, ~snd_rstn, 1'b0, bank};

  assign we0 = mshramen & ~bus.wr_n;
  assign we1 = sshramen & ~sub_rnw;

  // Address decode, registered one clock behind the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      vram_cs  <= 1'b0;
      ram_cs   <= 1'b0;
      vctrl_cs <= 1'b0;
      vflag_cs <= 1'b0;
      bank_cs  <= 1'b0;
      pal_cs   <= 1'b0;
    end else begin
      rom_cs   <= mem_acc & (bus.A < 16'hC000);
      vram_cs  <= mem_acc & (bus.A >= 16'hC000) & (bus.A <= 16'hDFFF);
      ram_cs   <= mem_acc & (bus.A >= 16'hE000) & (bus.A <= 16'hEFFF);
      vctrl_cs <= mem_acc & (bus.A >= 16'hF000) & (bus.A <= 16'hF3FF);
      vflag_cs <= mem_acc & (bus.A >= 16'hF400) & (bus.A <= 16'hF5FF) & ~bus.wr_n;
      bank_cs  <= mem_acc & (bus.A >= 16'hF600) & (bus.A <= 16'hF7FF) & ~bus.wr_n;
      pal_cs   <= mem_acc & (bus.A >= 16'hF800);
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (rom_cs)                  rd_mux = rom_data;
    else if (ram_cs)             rd_mux = ram_q;
    else if (vram_cs | vctrl_cs) rd_mux = vram_dout;
    else if (pal_cs)             rd_mux = pal_dout;
  end

  // Read data, bank latch and sound reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cpu_din <= 8'h00;
      bank        <= 3'd0;
      snd_rstn    <= 1'b0;
    end else begin
      bus.cpu_din <= rd_mux;
      if (bank_cs) begin
        bank     <= bus.cpu_dout[2:0];
        snd_rstn <= bus.cpu_dout[4];
      end
    end
  end

  // Vblank IRQ; the edge detector loads the live level so reset never fakes an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvbl_l    <= LVBL;
      bus.int_n <= 1'b1;
    end else begin
      lvbl_l <= LVBL;
      if (!bus.iorq_n)
        bus.int_n <= 1'b1;
      else if (lvbl_l && !LVBL)
        bus.int_n <= 1'b0;
    end
  end

  // Ownership flags: each side waits for the other to drop; main wins ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mshramen <= 1'b0;
      sshramen <= 1'b0;
    end else begin
      if (!ram_cs)
        mshramen <= 1'b0;
      else if (!sshramen)
        mshramen <= 1'b1;

      if (!shr_cs)
        sshramen <= 1'b0;
      else if (!mshramen && !ram_cs)
        sshramen <= 1'b1;
    end
  end

  // True dual-port RAM, read-before-write on both ports
  always_ff @(posedge clk) begin
    ram_q    <= mem[addr0];
    shr_dout <= mem[shr_addr];
    if (we0) mem[addr0]    <= bus.cpu_dout;
    if (we1) mem[shr_addr] <= shr_din;
  end

endmodule

// File: tb/tb_kiwi_cpu_glue.sv
// Directed-vector bench for kiwi_cpu_glue.
`timescale 1ns/1ps
module tb_kiwi_cpu_glue;
  localparam int unsigned AW = 13;

  logic clk = 1'b0;
  logic rst;
  logic LVBL;
  logic rom_cs, vram_cs, vctrl_cs, vflag_cs, pal_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data, vram_dout, pal_dout;
  logic [8:0]  hcnt;
  logic [AW-1:0] shr_addr;
  logic [7:0]  shr_din;
  logic        sub_rnw, shr_cs;
  logic [7:0]  shr_dout;
  logic        mshramen, snd_rstn;
  logic [7:0]  st_dout;

  int n_vec = 0;
  int n_err = 0;

  kiwi_cpu_glue_if bus();

  kiwi_cpu_glue #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .LVBL(LVBL),
    .rom_cs(rom_cs), .vram_cs(vram_cs), .vctrl_cs(vctrl_cs),
    .vflag_cs(vflag_cs), .pal_cs(pal_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .vram_dout(vram_dout), .pal_dout(pal_dout),
    .hcnt(hcnt), .shr_addr(shr_addr), .shr_din(shr_din),
    .sub_rnw(sub_rnw), .shr_cs(shr_cs), .shr_dout(shr_dout),
    .mshramen(mshramen), .snd_rstn(snd_rstn), .st_dout(st_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.mreq_n = 1'b1;
    bus.wr_n   = 1'b1;
    bus.rfsh_n = 1'b1;
  endtask

  task automatic bus_acc(input logic [15:0] a, input logic wr, input logic [7:0] d);
    bus.A        = a;
    bus.cpu_dout = d;
    bus.mreq_n   = 1'b0;
    bus.rfsh_n   = 1'b1;
    bus.wr_n     = ~wr;
  endtask

  initial begin
    rst = 1'b1;
    LVBL = 1'b1;
    bus.cpu_cen = 1'b1; bus.A = 16'h0000; bus.cpu_dout = 8'h00;
    bus.iorq_n = 1'b1;
    bus_idle();
    rom_data = 8'h00; vram_dout = 8'h00; pal_dout = 8'h00; hcnt = 9'd0;
    shr_addr = '0; shr_din = 8'h00; sub_rnw = 1'b1; shr_cs = 1'b0;

    tick(3);
    chk("rst_int_n",   32'(bus.int_n), 32'h1);
    chk("rst_cpu_din", 32'(bus.cpu_din), 32'h00);
    chk("rst_st_dout", 32'(st_dout), 32'h10);
    chk("rst_cs", 32'({rom_cs, vram_cs, vctrl_cs, vflag_cs, pal_cs, mshramen}), 32'h0);
    rst = 1'b0;
    tick(3);
    chk("no_spurious_irq", 32'(bus.int_n), 32'h1);

    // Bank / sound-reset latch
    bus_acc(16'hF600, 1'b1, 8'h13);
    #1 chk("cpu_rnw_wr", 32'(bus.cpu_rnw), 32'h0);
    bus.cpu_cen = 1'b0;
    #1 chk("cpu_rnw_cen", 32'(bus.cpu_rnw), 32'h1);
    bus.cpu_cen = 1'b1;
    tick(2);
    chk("bank_st_dout", 32'(st_dout), 32'h03);
    chk("snd_rstn", 32'(snd_rstn), 32'h1);
    bus_idle();
    tick(2);

    // ROM banking and read path
    bus.A = 16'h8123;
    #1 chk("rom_addr_bank", 32'(rom_addr), 32'h0C123);
    rom_data = 8'h3C;
    bus_acc(16'h4123, 1'b0, 8'h00);
    #1 chk("rom_addr_lo", 32'(rom_addr), 32'h04123);
    tick(1);
    chk("rom_cs", 32'(rom_cs), 32'h1);
    tick(1);
    chk("rom_rd", 32'(bus.cpu_din), 32'h3C);

    pal_dout = 8'h99;
    bus_acc(16'hF800, 1'b0, 8'h00);
    tick(1);
    chk("pal_cs", 32'(pal_cs), 32'h1);
    tick(1);
    chk("pal_rd", 32'(bus.cpu_din), 32'h99);

    bus_acc(16'hF400, 1'b1, 8'h00);
    tick(1);
    chk("vflag_wr", 32'(vflag_cs), 32'h1);
    bus.wr_n = 1'b1;
    tick(1);
    chk("vflag_rd_none", 32'(vflag_cs), 32'h0);
    bus_acc(16'hF000, 1'b0, 8'h00);
    tick(1);
    chk("vctrl_cs", 32'(vctrl_cs), 32'h1);
    bus_idle();
    tick(2);

    // Vblank interrupt
    LVBL = 1'b0;
    tick(1);
    chk("irq_set", 32'(bus.int_n), 32'h0);
    tick(3);
    chk("irq_hold", 32'(bus.int_n), 32'h0);
    bus.iorq_n = 1'b0;
    tick(1);
    chk("irq_ack", 32'(bus.int_n), 32'h1);
    bus.iorq_n = 1'b1;
    tick(3);
    chk("irq_no_reassert", 32'(bus.int_n), 32'h1);
    LVBL = 1'b1;
    tick(2);
    LVBL = 1'b0;
    bus.iorq_n = 1'b0;
    tick(1);
    chk("irq_clear_wins", 32'(bus.int_n), 32'h1);
    bus.iorq_n = 1'b1;
    tick(2);
    chk("irq_after_tie", 32'(bus.int_n), 32'h1);

    // Main writes shared RAM, sub reads it back
    bus_acc(16'hE010, 1'b1, 8'hA5);
    tick(2);
    chk("main_grant", 32'(mshramen), 32'h1);
    tick(1);
    bus_idle();
    tick(2);
    chk("main_release", 32'(mshramen), 32'h0);
    shr_addr = AW'(16'h010);
    shr_cs = 1'b1;
    tick(2);
    chk("sub_rd", 32'(shr_dout), 32'hA5);

    // Sub holds the RAM: main is stalled and its write is dropped
    bus_acc(16'hE010, 1'b1, 8'hEE);
    tick(1);
    chk("contend_busy", 32'(bus.dev_busy), 32'h1);
    tick(2);
    chk("contend_no_grant", 32'(mshramen), 32'h0);
    bus.wr_n = 1'b1;
    shr_cs = 1'b0;
    tick(2);
    chk("late_grant", 32'(mshramen), 32'h1);
    chk("late_not_busy", 32'(bus.dev_busy), 32'h0);
    tick(2);
    chk("denied_write", 32'(bus.cpu_din), 32'hA5);
    bus_idle();
    tick(2);

    // Video region wait states and VRAM read latency
    vram_dout = 8'h5A;
    hcnt = 9'd1;
    bus_acc(16'hC000, 1'b0, 8'h00);
    #1 chk("obj_busy", 32'(bus.dev_busy), 32'h1);
    hcnt = 9'd4;
    #1 chk("obj_idle", 32'(bus.dev_busy), 32'h0);
    tick(1);
    chk("vram_cs", 32'(vram_cs), 32'h1);
    tick(1);
    chk("vram_rd", 32'(bus.cpu_din), 32'h5A);
    bus_idle();
    tick(2);

    // Refresh cycles select nothing and cannot write
    bus_acc(16'hE020, 1'b1, 8'h11);
    tick(3);
    bus_idle();
    tick(2);
    hcnt = 9'd1;
    bus_acc(16'hC000, 1'b1, 8'h77);
    bus.rfsh_n = 1'b0;
    #1 chk("rfsh_no_busy", 32'(bus.dev_busy), 32'h0);
    bus.A = 16'hE020;
    tick(1);
    chk("rfsh_no_cs", 32'({rom_cs, vram_cs, vctrl_cs, vflag_cs, pal_cs}), 32'h0);
    tick(2);
    chk("rfsh_no_grant", 32'(mshramen), 32'h0);
    bus_idle();
    hcnt = 9'd0;
    shr_addr = AW'(16'h020);
    shr_cs = 1'b1;
    tick(2);
    chk("rfsh_no_write", 32'(shr_dout), 32'h11);
    shr_cs = 1'b0;
    tick(2);

    // Asynchronous reset clears the latch without a clock edge
    #2 rst = 1'b1;
    #1 chk("async_rst_st", 32'(st_dout), 32'h10);
    chk("async_rst_din", 32'(bus.cpu_din), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/kiwi_cpu_glue.md
KIWI_CPU_GLUE -- requirements
Module: kiwi_cpu_glue

Interface
REQ-001 Parameter AW, default 13, shared-RAM address width (8 KiB x 8).
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_cen  in  1  Z80 clock enable; LVBL  in  1  vertical blank, active-low.
REQ-005 A  in  16  Z80 address; cpu_dout  in  8  Z80 write data.
REQ-006 mreq_n, rfsh_n, wr_n, iorq_n  in  1 each  Z80 strobes, active-low.
REQ-007 cpu_din  out  8  registered read data to Z80; int_n  out  1  Z80 interrupt; dev_busy  out  1  wait request.
REQ-008 cpu_rnw  out  1  external write strobe, low = write.
REQ-009 rom_cs, vram_cs, vctrl_cs, vflag_cs, pal_cs  out  1 each  registered chip selects.
REQ-010 rom_addr  out  17; rom_data  in  8; vram_dout, pal_dout  in  8; hcnt  in  9  horizontal counter.
REQ-011 shr_addr  in  AW; shr_din  in  8; sub_rnw  in  1; shr_cs  in  1; shr_dout  out  8  sub-CPU port.
REQ-012 mshramen  out  1  main owns RAM; snd_rstn  out  1  sound CPU reset, active-low; st_dout  out  8  status.

Function
REQ-013 mem_acc = ~mreq_n & rfsh_n (combinational).
REQ-014 Chip selects registered, 1 clk latency, each gated by mem_acc: rom_cs A<0xC000; vram_cs 0xC000-0xDFFF; ram_cs (internal) 0xE000-0xEFFF; vctrl_cs 0xF000-0xF3FF; vflag_cs 0xF400-0xF5FF and wr_n=0; bank_cs (internal) 0xF600-0xF7FF and wr_n=0; pal_cs 0xF800-0xFFFF.
REQ-015 rom_addr = A[15] ? {bank[2:0],A[13:0]} : {2'b00,A[14],A[13:0]}.
REQ-016 cpu_din registered each clk, priority: rom_cs->rom_data, ram_cs->RAM port0 q, vram_cs|vctrl_cs->vram_dout, pal_cs->pal_dout, else 0x00.
REQ-017 On bank_cs=1: bank <= cpu_dout[2:0], snd_rstn <= cpu_dout[4]; otherwise hold.
REQ-018 st_dout = {3'b000, ~snd_rstn, 1'b0, bank}.
REQ-019 cpu_rnw = wr_n | ~cpu_cen.
REQ-020 IRQ flip-flop: falling edge of LVBL (rising ~LVBL, detected on clk) drives int_n=0; iorq_n=0 drives int_n=1; clear wins when simultaneous.
REQ-021 dev_busy combinational = (sshramen & ram_cs) | (obj_en & hcnt[1:0]!=0), obj_en = mem_acc & ((A[15:11]==5'b11110 & ~A[9]) | A[15:10]==6'b111100 | A[15:13]==3'b110).
REQ-022 Arbiter, first come first served: mshramen set when ram_cs & ~sshramen, cleared when ~ram_cs (clear dominates).
REQ-023 sshramen (internal) set when shr_cs & ~mshramen & ~ram_cs, cleared when ~shr_cs (clear dominates); main wins a same-cycle request.
REQ-024 Shared RAM: 2^AW x 8 true dual port, both ports on clk, synchronous read 1 clk latency, read-during-write returns old data.
REQ-025 Port0: addr A[AW-1:0], data cpu_dout, we = mshramen & ~wr_n, q to cpu_din mux; port1: shr_addr, shr_din, we = sshramen & ~sub_rnw, q = shr_dout.
REQ-026 Writes from a port without ownership are ignored; both ownership flags never high together.

Reset
REQ-027 On rst: bank=0, snd_rstn=0, mshramen=0, sshramen=0, int_n=1, all chip selects=0, cpu_din=0x00, LVBL edge detector primed to current level (no spurious IRQ).
REQ-028 RAM contents undefined after reset and not cleared.

Verification
REQ-029 Write 0x13 to 0xF600 with mreq_n=0, rfsh_n=1, wr_n=0 -> next clk bank=3, snd_rstn=1, st_dout=0x03; A=0x8123 -> rom_addr=0x0C123.
REQ-030 LVBL 1->0 -> int_n=0 within 2 clk; pulse iorq_n=0 -> int_n=1; LVBL steady -> no re-assert.
REQ-031 Main write 0xA5 to 0xE010, then sub read shr_addr=0x010 with shr_cs=1 after main release -> shr_dout=0xA5.
REQ-032 shr_cs held (sshramen=1) then main access 0xE000 -> dev_busy=1, mshramen stays 0 until shr_cs drops.
REQ-033 Read 0xC000 with hcnt=1 -> dev_busy=1; hcnt=4 -> dev_busy=0; vram_dout=0x5A -> cpu_din=0x5A 2 clk after address.
REQ-034 rfsh_n=0 with A=0xE000 -> no chip select asserted, no RAM write.
